// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types, sizes and priority search for the 8-way arbiter.
// Revision : 1.0  initial release
// ============================================================================
package arb_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set bit at or after ptr, wrapping; scanning offsets high-to-low
    // lets the smallest offset overwrite the result last.
    function automatic logic [IDX_W-1:0] rr_search(
        input logic [NREQ-1:0]  req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] w_idx;
        logic [IDX_W-1:0] w_result;
        w_result = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = ptr + IDX_W'(k);
            if (req[w_idx]) begin
                w_result = w_idx;
            end
        end
        return w_result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_1hot_3_to_8.sv
`default_nettype none
// ============================================================================
// Module   : decoder_1hot_3_to_8
// Brief    : Enable-gated one-hot decoder, 3-bit index to 8-bit vector.
// Revision : 1.0  initial release
// ============================================================================
module decoder_1hot_3_to_8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [NREQ-1:0]  o_onehot
);

    assign o_onehot = i_en ? (NREQ'(1) << i_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_8
// Brief    : Tick-paced round-robin arbiter for 8 requesters with hold timeout.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam logic       c_timeout_en = (HOLD_MAX != 0);
    localparam logic [7:0] c_hold_last  = 8'(HOLD_MAX - 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [7:0]       r_hold_cnt;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_grant_valid;
    logic             r_timeout;

    logic [IDX_W-1:0] w_winner;
    logic             w_cur_req;
    logic             w_expire;

    assign w_winner  = rr_search(req, r_ptr);
    assign w_cur_req = req[r_grant_idx];
    assign w_expire  = c_timeout_en && (r_hold_cnt == c_hold_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (tick && (|req)) begin
                        r_grant_idx   <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_hold_cnt    <= '0;
                        r_state       <= GRANT;
                    end
                end
                GRANT: begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                    // A requester dropping on the expiry cycle is a plain release.
                    if (!w_cur_req || w_expire) begin
                        r_state       <= IDLE;
                        r_grant_valid <= 1'b0;
                        r_grant_idx   <= '0;
                        r_ptr         <= r_grant_idx + IDX_W'(1);
                        r_timeout     <= w_cur_req;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    decoder_1hot_3_to_8 u_dec (
        .i_idx    (r_grant_idx),
        .i_en     (r_grant_valid),
        .o_onehot (grant)
    );

    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_8
// Brief    : Self-checking bench for rr_arbiter_8 at four HOLD_MAX settings.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       tick;
    logic [7:0] req         [4];
    logic [7:0] grant       [4];
    logic [2:0] grant_idx   [4];
    logic       grant_valid [4];
    logic       timeout     [4];

    int total = 0;
    int bad   = 0;

    rr_arbiter_8 #(.HOLD_MAX(15)) u_dut0 (.clk(clk), .reset(reset), .tick(tick), .req(req[0]),
        .grant(grant[0]), .grant_idx(grant_idx[0]), .grant_valid(grant_valid[0]), .timeout(timeout[0]));
    rr_arbiter_8 #(.HOLD_MAX(2))  u_dut1 (.clk(clk), .reset(reset), .tick(tick), .req(req[1]),
        .grant(grant[1]), .grant_idx(grant_idx[1]), .grant_valid(grant_valid[1]), .timeout(timeout[1]));
    rr_arbiter_8 #(.HOLD_MAX(0))  u_dut2 (.clk(clk), .reset(reset), .tick(tick), .req(req[2]),
        .grant(grant[2]), .grant_idx(grant_idx[2]), .grant_valid(grant_valid[2]), .timeout(timeout[2]));
    rr_arbiter_8 #(.HOLD_MAX(5))  u_dut3 (.clk(clk), .reset(reset), .tick(tick), .req(req[3]),
        .grant(grant[3]), .grant_idx(grant_idx[3]), .grant_valid(grant_valid[3]), .timeout(timeout[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner, cycles held so far, next-priority index.
    int m_valid [4];
    int m_idx   [4];
    int m_ptr   [4];
    int m_held  [4];
    int m_to    [4];
    int hold_of [4] = '{15, 2, 0, 5};

    initial begin
        for (int d = 0; d < 4; d++) begin
            m_valid[d] = 0; m_idx[d] = 0; m_ptr[d] = 0; m_held[d] = 0; m_to[d] = 0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (reset) begin
                m_valid[d] = 0; m_idx[d] = 0; m_ptr[d] = 0; m_held[d] = 0; m_to[d] = 0;
            end else if (m_valid[d] == 0) begin
                m_to[d] = 0;
                if (tick && req[d] != 8'h00) begin
                    for (int k = 7; k >= 0; k--) begin
                        if (req[d][(m_ptr[d] + k) % 8]) m_idx[d] = (m_ptr[d] + k) % 8;
                    end
                    m_valid[d] = 1;
                    m_held[d]  = 1;
                end
            end else if (!req[d][m_idx[d]]) begin
                m_valid[d] = 0; m_ptr[d] = (m_idx[d] + 1) % 8; m_idx[d] = 0; m_to[d] = 0;
            end else if (hold_of[d] != 0 && m_held[d] >= hold_of[d]) begin
                m_valid[d] = 0; m_ptr[d] = (m_idx[d] + 1) % 8; m_idx[d] = 0; m_to[d] = 1;
            end else begin
                m_held[d] = m_held[d] + 1;
            end
        end
    end

    logic [7:0] exp_grant;
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            exp_grant = (m_valid[d] != 0) ? (8'h01 << m_idx[d]) : 8'h00;
            chk($sformatf("model_valid[%0d]", d), 32'(grant_valid[d]), 32'(m_valid[d]));
            chk($sformatf("model_grant[%0d]", d), 32'(grant[d]), 32'(exp_grant));
            chk($sformatf("model_idx[%0d]", d), 32'(grant_idx[d]), 32'(m_idx[d]));
            chk($sformatf("model_timeout[%0d]", d), 32'(timeout[d]), 32'(m_to[d]));
        end
    end

    int seq[$];
    int exp_seq[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int n_grant, n_to, n_valid;
    logic prev_v;

    initial begin
        reset = 1'b1;
        tick  = 1'b1;
        for (int d = 0; d < 4; d++) req[d] = 8'h00;
        req[0] = 8'hFF;

        // Reset with requests pending, then first grant to index 0
        repeat (2) begin
            @(negedge clk);
            chk("rst_grant", 32'(grant[0]), 32'h0);
            chk("rst_valid", 32'(grant_valid[0]), 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("first_grant", 32'(grant[0]), 32'h01);
        chk("first_idx", 32'(grant_idx[0]), 32'd0);
        req[0] = 8'h00;
        @(negedge clk);
        chk("first_release", 32'(grant_valid[0]), 32'h0);

        // Tick gating
        tick   = 1'b0;
        req[0] = 8'h10;
        repeat (5) begin
            @(negedge clk);
            chk("tick_gate_valid", 32'(grant_valid[0]), 32'h0);
        end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("tick_grant", 32'(grant[0]), 32'h10);
        chk("tick_idx", 32'(grant_idx[0]), 32'd4);
        req[0] = 8'h00;
        @(negedge clk);

        // Voluntary release of index 3, then wrap past 3 to index 0
        req[0] = 8'h08;
        tick   = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("vol_idx", 32'(grant_idx[0]), 32'd3);
        end
        req[0] = 8'h00;
        @(negedge clk);
        chk("vol_drop", 32'(grant_valid[0]), 32'h0);
        chk("vol_no_timeout", 32'(timeout[0]), 32'h0);
        req[0] = 8'h09;
        @(negedge clk);
        chk("vol_wrap_grant", 32'(grant[0]), 32'h01);
        req[0] = 8'h00;
        @(negedge clk);

        // Reset in the middle of a grant to index 6
        req[0] = 8'h40;
        @(negedge clk);
        chk("mid_grant", 32'(grant[0]), 32'h40);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_grant", 32'(grant[0]), 32'h0);
        chk("mid_rst_valid", 32'(grant_valid[0]), 32'h0);
        chk("mid_rst_idx", 32'(grant_idx[0]), 32'h0);
        chk("mid_rst_timeout", 32'(timeout[0]), 32'h0);
        reset  = 1'b0;
        req[0] = 8'h41;
        @(negedge clk);
        chk("post_rst_grant", 32'(grant[0]), 32'h01);
        req[0] = 8'h00;
        repeat (2) @(negedge clk);

        // Round robin, HOLD_MAX=2, all requesters
        req[1] = 8'hFF;
        prev_v = 1'b0; n_to = 0; n_valid = 0;
        repeat (27) begin
            @(negedge clk);
            if (grant_valid[1] && !prev_v) seq.push_back(int'(grant_idx[1]));
            prev_v = grant_valid[1];
            if (timeout[1]) n_to++;
            if (grant_valid[1]) n_valid++;
        end
        req[1] = 8'h00;
        chk("rr_count", 32'(seq.size()), 32'd9);
        for (int i = 0; i < 9 && i < seq.size(); i++) chk($sformatf("rr_seq[%0d]", i), 32'(seq[i]), 32'(exp_seq[i]));
        chk("rr_timeouts", 32'(n_to), 32'd9);
        chk("rr_valid_cycles", 32'(n_valid), 32'd18);
        repeat (2) @(negedge clk);

        // HOLD_MAX=0: no timeout over 300 cycles
        req[2] = 8'h01;
        prev_v = 1'b0; n_grant = 0; n_to = 0; n_valid = 0;
        repeat (300) begin
            @(negedge clk);
            if (grant_valid[2] && !prev_v) n_grant++;
            prev_v = grant_valid[2];
            if (timeout[2]) n_to++;
            if (grant_valid[2]) n_valid++;
        end
        req[2] = 8'h00;
        chk("h0_grants", 32'(n_grant), 32'd1);
        chk("h0_timeouts", 32'(n_to), 32'd0);
        chk("h0_valid_cycles", 32'(n_valid), 32'd300);
        @(negedge clk);
        chk("h0_release_to", 32'(timeout[2]), 32'h0);

        // HOLD_MAX=5: full hold then timeout
        req[3] = 8'h01;
        n_valid = 0; n_to = 0;
        repeat (6) begin
            @(negedge clk);
            if (grant_valid[3]) n_valid++;
            if (timeout[3]) n_to++;
        end
        chk("h5_valid_cycles", 32'(n_valid), 32'd5);
        chk("h5_timeout_now", 32'(timeout[3]), 32'h1);
        chk("h5_timeouts", 32'(n_to), 32'd1);
        req[3] = 8'h00;
        repeat (2) @(negedge clk);

        // HOLD_MAX=5: drop in the 5th cycle is a normal release
        req[3] = 8'h01;
        repeat (5) @(negedge clk);
        chk("tie_valid_5th", 32'(grant_valid[3]), 32'h1);
        req[3] = 8'h00;
        @(negedge clk);
        chk("tie_drop", 32'(grant_valid[3]), 32'h0);
        chk("tie_no_timeout", 32'(timeout[3]), 32'h0);
        @(negedge clk);
        chk("tie_no_timeout_late", 32'(timeout[3]), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
